// File: rtl/imm_gen_pipe_pkg.sv
// Shared definitions for the pipelined immediate generator.
// Contents: immediate format codes, RISC-V major opcodes, buffer entry metadata.
package imm_gen_pipe_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned SEL_W   = 3;

  // Immediate format codes; NONE marks formats with no immediate.
  typedef enum logic [SEL_W-1:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_JR   = 3'd5,
    IMM_CSR  = 3'd6,
    IMM_NONE = 3'd7
  } imm_sel_e;

  // Major opcodes, instr[6:0].
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_REG32  = 7'b0111011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Per-entry metadata held alongside the immediate and tag.
  typedef struct packed {
    logic             illegal;
    logic [SEL_W-1:0] sel;
  } imm_meta_t;

endpackage

// File: rtl/imm_gen_pipe_format.sv
// Combinational immediate formatter and optional opcode decoder.
// Ports: instr (raw word), sel_in (external format), sel_c (format applied),
//        illegal_c (unrecognised opcode, decode mode only), imm_c (XLEN immediate).
module imm_gen_pipe_format
  import imm_gen_pipe_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter bit          DECODE_SEL = 1'b1
) (
  input  logic [INSTR_W-1:0] instr,
  input  logic [SEL_W-1:0]   sel_in,
  output logic [SEL_W-1:0]   sel_c,
  output logic               illegal_c,
  output logic [XLEN-1:0]    imm_c
);

  imm_sel_e    sel_e;
  logic [31:0] imm32;
  logic        sgn;
  logic        unused_funct3;

  assign sgn           = instr[31];
  assign unused_funct3 = ^instr[13:12];

  // Format selection: decoded from opcode or taken from the control unit.
  if (DECODE_SEL) begin : g_decode
    logic unused_sel;
    assign unused_sel = ^sel_in;

    always_comb begin
      sel_e     = IMM_NONE;
      illegal_c = 1'b0;
      case (instr[6:0])
        OP_IMM, OP_LOAD: sel_e = IMM_I;
        OP_JALR:         sel_e = IMM_JR;
        OP_JAL:          sel_e = IMM_J;
        OP_LUI, OP_AUIPC: sel_e = IMM_U;
        OP_BRANCH:       sel_e = IMM_B;
        OP_STORE:        sel_e = IMM_S;
        OP_SYSTEM:       sel_e = instr[14] ? IMM_CSR : IMM_I;
        OP_IMM32: begin
          if (XLEN == 64) begin
            sel_e = IMM_I;
          end else begin
            illegal_c = 1'b1;
          end
        end
        OP_REG, OP_REG32: sel_e = IMM_NONE;
        default:          illegal_c = 1'b1;
      endcase
    end
  end else begin : g_external
    logic unused_opcode;
    assign unused_opcode = ^{instr[14], instr[6:0]};
    assign sel_e         = imm_sel_e'(sel_in);
    assign illegal_c     = 1'b0;
  end

  assign sel_c = sel_e;

  // Build a 32-bit immediate; every signed format carries its sign in bit 31.
  always_comb begin
    imm32 = 32'h0;
    case (sel_e)
      IMM_I, IMM_JR: imm32 = {{20{sgn}}, instr[31:20]};
      IMM_S:   imm32 = {{20{sgn}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{sgn}}, sgn, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'h000};
      IMM_J:   imm32 = {{11{sgn}}, sgn, instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_CSR: imm32 = {27'h0, instr[19:15]};
      default: imm32 = 32'h0;
    endcase
  end

  // CSR is zero-extended by construction (bit 31 is 0), so one sign extend covers all.
  assign imm_c = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: formats the incoming instruction and holds the
// result in a 2-entry ready/valid buffer with flush.
// Ports: clk, rst (sync, active-high), flush; input handshake in_valid/in_ready
//        with in_instr, in_imm_sel, in_tag; output handshake out_valid/out_ready
//        with out_imm, out_sel, out_tag, out_illegal.
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter bit          DECODE_SEL = 1'b1,
  parameter int unsigned TAG_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [SEL_W-1:0]   in_imm_sel,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_imm,
  output logic [SEL_W-1:0]   out_sel,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_illegal
);

  if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  logic [SEL_W-1:0] fmt_sel;
  logic             fmt_illegal;
  logic [XLEN-1:0]  fmt_imm;

  imm_gen_pipe_format #(
    .XLEN       (XLEN),
    .DECODE_SEL (DECODE_SEL)
  ) u_format (
    .instr     (in_instr),
    .sel_in    (in_imm_sel),
    .sel_c     (fmt_sel),
    .illegal_c (fmt_illegal),
    .imm_c     (fmt_imm)
  );

  logic [1:0]             count_q, count_d;
  logic                   wr_ptr_q, wr_ptr_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic [1:0][XLEN-1:0]   imm_q, imm_d;
  logic [1:0][TAG_W-1:0]  tag_q, tag_d;
  imm_meta_t [1:0]        meta_q, meta_d;
  logic                   push, pop;

  // Ready depends on occupancy only, so a full buffer never looks through to out_ready.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_imm     = imm_q[rd_ptr_q];
  assign out_tag     = tag_q[rd_ptr_q];
  assign out_sel     = meta_q[rd_ptr_q].sel;
  assign out_illegal = meta_q[rd_ptr_q].illegal;

  // Next-state: flush overrides both push and pop.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    imm_d    = imm_q;
    tag_d    = tag_q;
    meta_d   = meta_q;
    if (flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) begin
        imm_d[wr_ptr_q]         = fmt_imm;
        tag_d[wr_ptr_q]         = in_tag;
        meta_d[wr_ptr_q].sel     = fmt_sel;
        meta_d[wr_ptr_q].illegal = fmt_illegal;
        wr_ptr_d                = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // State register; reset also clears storage so outputs read zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      imm_q    <= '0;
      tag_q    <= '0;
      meta_q   <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      imm_q    <= imm_d;
      tag_q    <= tag_d;
      meta_q   <= meta_d;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three instances (XLEN=32 decode, XLEN=64 decode,
// XLEN=64 external select) share stimulus; a scoreboard tracks all three.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = 32'h0;
  logic [2:0]  in_imm_sel = 3'd0;
  logic [7:0]  in_tag = 8'h0;

  logic rdy_a, vld_a, ill_a, rdy_b, vld_b, ill_b, rdy_c, vld_c, ill_c;
  logic [31:0] imm_a;
  logic [63:0] imm_b, imm_c;
  logic [2:0]  sel_a, sel_b, sel_c;
  logic [7:0]  tag_a, tag_b, tag_c;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .DECODE_SEL(1'b1), .TAG_W(8)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_a),
    .in_instr(in_instr), .in_imm_sel(in_imm_sel), .in_tag(in_tag),
    .out_valid(vld_a), .out_ready(out_ready), .out_imm(imm_a), .out_sel(sel_a),
    .out_tag(tag_a), .out_illegal(ill_a));

  imm_gen_pipe #(.XLEN(64), .DECODE_SEL(1'b1), .TAG_W(8)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_b),
    .in_instr(in_instr), .in_imm_sel(in_imm_sel), .in_tag(in_tag),
    .out_valid(vld_b), .out_ready(out_ready), .out_imm(imm_b), .out_sel(sel_b),
    .out_tag(tag_b), .out_illegal(ill_b));

  imm_gen_pipe #(.XLEN(64), .DECODE_SEL(1'b0), .TAG_W(8)) u_c (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_c),
    .in_instr(in_instr), .in_imm_sel(in_imm_sel), .in_tag(in_tag),
    .out_valid(vld_c), .out_ready(out_ready), .out_imm(imm_c), .out_sel(sel_c),
    .out_tag(tag_c), .out_illegal(ill_c));

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [63:0] imm_a, imm_b, imm_c;
    logic [2:0]  sel_a, sel_b, sel_c;
    logic        ill_a, ill_b;
    logic [7:0]  tag;
  } exp_t;

  exp_t sbq[$];
  int   pop_tags[$];
  int   pop_cnt = 0;

  localparam logic [6:0] OPS [12] = '{7'h13, 7'h03, 7'h67, 7'h6F, 7'h37, 7'h17,
                                      7'h63, 7'h23, 7'h73, 7'h1B, 7'h33, 7'h3B};

  // Returns {illegal, sel}.
  function automatic logic [3:0] ref_dec(input logic [31:0] ins, input bit x64);
    logic [2:0] s;
    logic il;
    s = 3'd7;
    il = 1'b0;
    case (ins[6:0])
      7'h13, 7'h03: s = 3'd0;
      7'h67:        s = 3'd5;
      7'h6F:        s = 3'd4;
      7'h37, 7'h17: s = 3'd3;
      7'h63:        s = 3'd2;
      7'h23:        s = 3'd1;
      7'h73:        s = ins[14] ? 3'd6 : 3'd0;
      7'h1B:        if (x64) s = 3'd0; else il = 1'b1;
      7'h33, 7'h3B: s = 3'd7;
      default:      il = 1'b1;
    endcase
    return {il, s};
  endfunction

  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] s,
                                          input bit x64);
    logic [63:0] v;
    logic b;
    b = ins[31];
    case (s)
      3'd0, 3'd5: v = {{52{b}}, ins[31:20]};
      3'd1: v = {{52{b}}, ins[31:25], ins[11:7]};
      3'd2: v = {{51{b}}, b, ins[7], ins[30:25], ins[11:8], 1'b0};
      3'd3: v = {{32{b}}, ins[31:12], 12'h000};
      3'd4: v = {{43{b}}, b, ins[19:12], ins[20], ins[30:21], 1'b0};
      3'd6: v = {59'h0, ins[19:15]};
      default: v = 64'h0;
    endcase
    if (!x64) v[63:32] = 32'h0;
    return v;
  endfunction

  function automatic exp_t mk_exp(input logic [31:0] ins, input logic [2:0] isel,
                                  input logic [7:0] tag);
    exp_t e;
    logic [3:0] da, db;
    da = ref_dec(ins, 1'b0);
    db = ref_dec(ins, 1'b1);
    e.sel_a = da[2:0]; e.ill_a = da[3];
    e.sel_b = db[2:0]; e.ill_b = db[3];
    e.sel_c = isel;
    e.imm_a = ref_imm(ins, da[2:0], 1'b0);
    e.imm_b = ref_imm(ins, db[2:0], 1'b1);
    e.imm_c = ref_imm(ins, isel, 1'b1);
    e.tag   = tag;
    return e;
  endfunction

  // ---------------- scoreboard monitor ----------------
  exp_t e;
  bit   was_full;
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
    end else begin
      was_full = (sbq.size() == 2);
      checks++;
      if ({vld_a, vld_b, vld_c, rdy_a, rdy_b, rdy_c} !==
          {{3{sbq.size() != 0}}, {3{!was_full}}}) begin
        failures++;
        $display("FAIL sb_handshake t=%0t valid/ready got=%b%b%b/%b%b%b exp occupancy=%0d",
                 $time, vld_a, vld_b, vld_c, rdy_a, rdy_b, rdy_c, sbq.size());
      end
      if (sbq.size() != 0) begin
        e = sbq[0];
        checks++;
        if ({imm_a, sel_a, tag_a, ill_a} !== {e.imm_a[31:0], e.sel_a, e.tag, e.ill_a}) begin
          failures++;
          $display("FAIL sb_head_a t=%0t got imm=%h sel=%0d tag=%h ill=%b exp imm=%h sel=%0d tag=%h ill=%b",
                   $time, imm_a, sel_a, tag_a, ill_a, e.imm_a[31:0], e.sel_a, e.tag, e.ill_a);
        end
        checks++;
        if ({imm_b, sel_b, tag_b, ill_b} !== {e.imm_b, e.sel_b, e.tag, e.ill_b}) begin
          failures++;
          $display("FAIL sb_head_b t=%0t got imm=%h sel=%0d tag=%h ill=%b exp imm=%h sel=%0d tag=%h ill=%b",
                   $time, imm_b, sel_b, tag_b, ill_b, e.imm_b, e.sel_b, e.tag, e.ill_b);
        end
        checks++;
        if ({imm_c, sel_c, tag_c, ill_c} !== {e.imm_c, e.sel_c, e.tag, 1'b0}) begin
          failures++;
          $display("FAIL sb_head_c t=%0t got imm=%h sel=%0d tag=%h ill=%b exp imm=%h sel=%0d tag=%h ill=0",
                   $time, imm_c, sel_c, tag_c, ill_c, e.imm_c, e.sel_c, e.tag);
        end
        if (!flush && out_ready) begin
          pop_tags.push_back(int'(e.tag));
          pop_cnt++;
          sbq.delete(0);
        end
      end
      if (flush) begin
        sbq.delete();
      end else if (in_valid && !was_full) begin
        sbq.push_back(mk_exp(in_instr, in_imm_sel, in_tag));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 8'hAA;
    repeat (2) cyc();
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({vld_a, vld_b, vld_c} !== 3'b000 || {rdy_a, rdy_b, rdy_c} !== 3'b111) begin
      failures++;
      $display("FAIL reset_handshake got valid=%b%b%b ready=%b%b%b exp valid=000 ready=111",
               vld_a, vld_b, vld_c, rdy_a, rdy_b, rdy_c);
    end
    checks++;
    if ({imm_a, sel_a, tag_a, ill_a} !== 44'h0 || imm_b !== 64'h0 || {sel_b, tag_b, ill_b} !== 12'h0) begin
      failures++;
      $display("FAIL reset_storage got imm_a=%h sel_a=%0d tag_a=%h ill_a=%b imm_b=%h exp all zero",
               imm_a, sel_a, tag_a, ill_a, imm_b);
    end
  endtask

  localparam logic [31:0] V_INS [7] = '{32'hFFF00093, 32'h800000B7, 32'hFFDFF06F,
                                        32'h00000463, 32'h000FD073, 32'h0000007F, 32'h0010009B};
  localparam logic [31:0] V_IMMA [7] = '{32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFC,
                                         32'h8, 32'h1F, 32'h0, 32'h0};
  localparam logic [63:0] V_IMMB [7] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF80000000,
                                         64'hFFFFFFFFFFFFFFFC, 64'h8, 64'h1F, 64'h0, 64'h1};
  localparam logic [2:0] V_SA [7] = '{3'd0, 3'd3, 3'd4, 3'd2, 3'd6, 3'd7, 3'd7};
  localparam logic [2:0] V_SB [7] = '{3'd0, 3'd3, 3'd4, 3'd2, 3'd6, 3'd7, 3'd0};
  localparam logic V_IA [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam logic V_IB [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  task automatic test_decode();
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cyc();
      in_valid = 1'b1; in_instr = V_INS[i]; in_tag = 8'(16 + i); in_imm_sel = 3'(i);
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({vld_a, imm_a, sel_a, ill_a} !== {1'b1, V_IMMA[i], V_SA[i], V_IA[i]}) begin
        failures++;
        $display("FAIL decode32[%0d] instr=%h got valid=%b imm=%h sel=%0d ill=%b exp valid=1 imm=%h sel=%0d ill=%b",
                 i, V_INS[i], vld_a, imm_a, sel_a, ill_a, V_IMMA[i], V_SA[i], V_IA[i]);
      end
      checks++;
      if ({vld_b, imm_b, sel_b, ill_b} !== {1'b1, V_IMMB[i], V_SB[i], V_IB[i]}) begin
        failures++;
        $display("FAIL decode64[%0d] instr=%h got valid=%b imm=%h sel=%0d ill=%b exp valid=1 imm=%h sel=%0d ill=%b",
                 i, V_INS[i], vld_b, imm_b, sel_b, ill_b, V_IMMB[i], V_SB[i], V_IB[i]);
      end
    end
    repeat (2) cyc();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    pop_tags.delete();
    cyc(); in_valid = 1'b1; in_instr = 32'h00100093; in_tag = 8'd1;
    cyc(); in_tag = 8'd2;
    cyc(); in_tag = 8'd3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({rdy_a, vld_a, tag_a} !== {1'b0, 1'b1, 8'd1}) begin
        failures++;
        $display("FAIL full_hold[%0d] got ready=%b valid=%b tag=%0d exp ready=0 valid=1 tag=1",
                 k, rdy_a, vld_a, tag_a);
      end
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    cyc(); in_valid = 1'b0;
    repeat (3) cyc();
    checks++;
    if (pop_tags.size() != 3 || pop_tags[0] != 1 || pop_tags[1] != 2 || pop_tags[2] != 3) begin
      failures++;
      $display("FAIL b2b_order got count=%0d tags=%p exp tags 1,2,3", pop_tags.size(), pop_tags);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    cyc(); in_valid = 1'b1; in_tag = 8'd4;
    cyc(); in_tag = 8'd5;
    cyc(); in_tag = 8'd6; flush = 1'b1;
    cyc(); flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({vld_a, vld_b, vld_c, rdy_a, rdy_b, rdy_c} !== 6'b000111) begin
      failures++;
      $display("FAIL flush_state got valid=%b%b%b ready=%b%b%b exp valid=000 ready=111",
               vld_a, vld_b, vld_c, rdy_a, rdy_b, rdy_c);
    end
    out_ready = 1'b1;
    pop_tags.delete();
    repeat (3) cyc();
    checks++;
    if (pop_tags.size() != 0 || vld_a !== 1'b0) begin
      failures++;
      $display("FAIL flush_drop got emitted=%0d valid=%b exp emitted=0 valid=0", pop_tags.size(), vld_a);
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_instr = $urandom(); in_tag = 8'(32 + i);
      cyc();
    end
    rst = 1'b1; in_tag = 8'd48;
    cyc();
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({vld_a, vld_b, vld_c, rdy_a} !== 4'b0001) begin
      failures++;
      $display("FAIL reset_midstream got valid=%b%b%b ready=%b exp valid=000 ready=1",
               vld_a, vld_b, vld_c, rdy_a);
    end
    cyc();
  endtask

  task automatic rand_beat();
    in_instr = $urandom();
    if ($urandom_range(0, 1) == 1) in_instr[6:0] = OPS[$urandom_range(0, 11)];
    in_imm_sel = 3'($urandom_range(0, 7));
    in_tag = 8'($urandom_range(0, 255));
  endtask

  task automatic test_random();
    pop_cnt = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cyc();
      in_valid = 1'b1;
      rand_beat();
    end
    cyc(); in_valid = 1'b0;
    repeat (2) cyc();
    checks++;
    if (pop_cnt != 100) begin
      failures++;
      $display("FAIL throughput got pops=%0d exp pops=100", pop_cnt);
    end
    for (int i = 0; i < 300; i++) begin
      cyc();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      rand_beat();
    end
    cyc(); in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) cyc();
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL random_drain got pending=%0d exp pending=0", sbq.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
